// File: rtl/jt89_pkg.sv
// Shared constants and the sound-to-PCM conversion for the jt89 audio output path.
package jt89_pkg;

  localparam int JT89_SOUND_W     = 11;
  localparam int JT89_PCM_W       = 16;
  localparam int JT89_FRAME_SLOTS = 32;
  localparam int JT89_SLOT_W      = $clog2(JT89_FRAME_SLOTS);
  localparam logic [JT89_PCM_W-1:0] JT89_PCM_MID = 16'h0000;

  // Unsigned 11-bit sound to signed 16-bit PCM: (s - 1024) << 5.
  // Flipping the MSB re-centres the unsigned range around zero.
  function automatic logic [JT89_PCM_W-1:0] jt89_to_pcm(input logic [JT89_SOUND_W-1:0] s);
    return {~s[JT89_SOUND_W-1], s[JT89_SOUND_W-2:0], 5'b00000};
  endfunction

endpackage

// File: rtl/jt89_bclk_gen.sv
// Bit-clock divider: toggles an internal phase every BCLK_DIV clk cycles and
// reports each toggle as a one-cycle rise or fall pulse.
module jt89_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0] div_cnt_q, div_cnt_d;
  logic       phase_q, phase_d;
  logic       wrap_s;

  assign wrap_s = (div_cnt_q == DIV_LAST);

  // Next-state for the divider counter and bit-clock phase.
  always_comb begin
    div_cnt_d = div_cnt_q + 8'd1;
    phase_d   = phase_q;
    if (wrap_s) begin
      div_cnt_d = 8'd0;
      phase_d   = ~phase_q;
    end else begin
      phase_d   = phase_q;
    end
  end

  // Divider and phase registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= 8'd0;
      phase_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
    end
  end

  // The pulse marks the clk edge on which the phase toggles.
  assign rise_o = wrap_s & ~phase_q;
  assign fall_o = wrap_s &  phase_q;

endmodule

// File: rtl/jt89_i2s_tx.sv
// I2S stereo transmitter: holds the latest sound sample, snapshots it as PCM
// once per frame and shifts it out MSB first in both slots with the I2S
// one-bit delay after each word-select transition.
module jt89_i2s_tx
  import jt89_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic [JT89_SOUND_W-1:0] sound,
  input  logic                    mute,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    frame_strobe
);

  logic rise_s, fall_s;

  logic [JT89_SOUND_W-1:0] hold_q,  hold_d;
  logic [JT89_PCM_W-1:0]   snap_q,  snap_d;
  logic [JT89_PCM_W-1:0]   shift_q, shift_d;
  logic [JT89_SLOT_W-1:0]  slot_q,  slot_d;
  logic bclk_q,   bclk_d;
  logic lrclk_q,  lrclk_d;
  logic sdata_q,  sdata_d;
  logic strobe_q, strobe_d;

  jt89_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk_i  (clk),
    .rst_i  (rst),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // Frame sequencing: all slot-related state advances on bclk falling edges.
  always_comb begin
    hold_d   = hold_q;
    snap_d   = snap_q;
    shift_d  = shift_q;
    slot_d   = slot_q;
    bclk_d   = bclk_q;
    lrclk_d  = lrclk_q;
    sdata_d  = sdata_q;
    strobe_d = 1'b0;

    if (clk_en) begin
      hold_d = sound;
    end else begin
      hold_d = hold_q;
    end

    if (rise_s) begin
      bclk_d = 1'b1;
    end else if (fall_s) begin
      bclk_d  = 1'b0;
      slot_d  = slot_q + 5'd1;
      lrclk_d = slot_d[JT89_SLOT_W-1];
      if (slot_d == 5'd0) begin
        strobe_d = 1'b1;
        // hold_q is the pre-edge value, so a coincident clk_en lands in the next frame.
        snap_d   = mute ? JT89_PCM_MID : jt89_to_pcm(hold_q);
      end else begin
        snap_d   = snap_q;
      end
      if ((slot_d == 5'd1) || (slot_d == 5'd17)) begin
        shift_d = snap_q;
      end else begin
        shift_d = {shift_q[JT89_PCM_W-2:0], 1'b0};
      end
      sdata_d = shift_d[JT89_PCM_W-1];
    end else begin
      bclk_d = bclk_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q   <= 11'd0;
      snap_q   <= 16'd0;
      shift_q  <= 16'd0;
      slot_q   <= 5'd31;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b1;
      sdata_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      snap_q   <= snap_d;
      shift_q  <= shift_d;
      slot_q   <= slot_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      strobe_q <= strobe_d;
    end
  end

  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign frame_strobe = strobe_q;

endmodule

// File: doc/jt89_i2s_tx.md
Name: jt89_i2s_tx

Overview:
- Serial audio transmitter at the output end of the jt89 sound path.
- Samples the 11-bit unsigned mixed sound word on `clk_en` and converts it to signed 16-bit PCM.
- Shifts the PCM word out as a standard I2S stereo frame, with the same mono word in both slots.
- Generates its own bit clock (`bclk`), word-select (`lrclk`) and serial data (`sdata`) to drive an external DAC, plus a once-per-frame strobe for the system.

Parameters:
- BCLK_DIV, 4, number of `clk` cycles per `bclk` half-period (legal range 1..255); `bclk` period = 2*BCLK_DIV `clk` cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- clk_en  input  1  sample-valid enable from the sound path; `sound` is captured when high
- sound  input  11  unsigned mixed sound, 0..2047
- mute  input  1  when high at frame latch, the frame carries the PCM midpoint (0x0000)
- bclk  output  1  I2S bit clock
- lrclk  output  1  I2S word select (0 = left, 1 = right)
- sdata  output  1  I2S serial data, MSB first
- frame_strobe  output  1  one-`clk` pulse at the start of each frame (slot 0 entry)

Behaviour:
- Reset (async, `rst` high):
  - Outputs: `bclk`=0, `lrclk`=1, `sdata`=0, `frame_strobe`=0.
  - Internal state: `div_cnt`=0, slot counter=31, hold register=0, shift register=0, snapshot=0.
- Hold register:
  - On any `clk` edge with `clk_en`=1, hold <= `sound`.
  - Independent of frame timing; last value wins.
- Conversion to PCM:
  - pcm = {~hold[10], hold[9:0], 5'b00000}, i.e. (hold-1024)<<5 in two's complement.
  - Examples: 0 -> 0x8000, 1024 -> 0x0000, 2047 -> 0x7FE0.
- Divider:
  - `div_cnt` counts 0..BCLK_DIV-1.
  - At `div_cnt`==BCLK_DIV-1: `div_cnt` wraps to 0 and `bclk` toggles.
  - A 0->1 toggle is a rising edge; a 1->0 toggle is a falling edge.
- Slot counter:
  - 5 bits, 0..31, incremented modulo 32 on each `bclk` falling edge (same `clk` edge as the toggle).
- `lrclk`: registered, equals (slot >= 16) for the new slot; it changes on the falling edge.
- `frame_strobe`:
  - High for exactly the one `clk` cycle following the falling edge that enters slot 0.
  - The first strobe occurs at `clk` cycle 2*BCLK_DIV after reset release.
- Snapshot: on entry to slot 0, snapshot <= mute ? 0x0000 : pcm(hold).
- Shift register:
  - Loaded with snapshot on entry to slot 1 and again on entry to slot 17.
  - On every other falling edge it shifts left by 1.
- `sdata`:
  - Driven from the shift register MSB after each falling edge; stable across the following rising edge.
  - Slots 1..16 carry left bits 15..0; slots 17..31 carry right bits 15..1.
  - Slot 0 carries right bit 0 of the previous frame. This is the I2S one-bit delay after the `lrclk` transition.
- Frame period = 64*BCLK_DIV `clk` cycles.
- Samples arriving faster than the frame rate are decimated by last-value; slower arrival repeats the held value.
- Simultaneous events:
  - `clk_en` on the same edge as snapshot: snapshot uses the pre-edge hold value; the new sample goes into the next frame.
  - `mute` is sampled only at slot-0 entry; toggling mid-frame has no effect on the current frame.
- Reset mid-frame: all state returns to reset values immediately. `bclk` may show a truncated high phase; no glitch beyond that.
- BCLK_DIV=1: `bclk` toggles every `clk` cycle; all rules above still hold.

Decomposition:
- Shared package jt89_pkg:
  - JT89_SOUND_W=11, JT89_PCM_W=16, JT89_FRAME_SLOTS=32, JT89_PCM_MID=16'h0000.
  - A function for the 11-bit to PCM conversion.
- One natural sub-module, jt89_bclk_gen:
  - Contains the divider plus `bclk` toggle.
  - Outputs a rise pulse and a fall pulse to the frame logic.

Test Plan:
1. Reset release, BCLK_DIV=4 -> `bclk` first rises at cycle 4 and falls at cycle 8; `frame_strobe` pulses once at cycle 8; `lrclk` goes 1->0 at cycle 8; frame repeats every 256 cycles.
2. `sound`=1024 held, `mute`=0 -> both slots of the next frame carry 0x0000; slot 0 of the following frame = 0.
3. `sound`=2047 -> deserializing `sdata` on `bclk` rising edges, with `lrclk`-relative one-bit delay, yields left=right=0x7FE0; `sound`=0 yields 0x8000.
4. Sample change 1024->2047 with `clk_en` on the same cycle as slot-0 entry -> that frame sends 0x0000; next frame sends 0x7FE0.
5. `sound`=2047, `mute`=1 at slot 0 then 0 mid-frame -> whole frame 0x0000; next frame 0x7FE0.
6. Assert `rst` mid slot 20 -> `bclk`=0, `lrclk`=1, `sdata`=0 within the same cycle (async); after release, timing matches scenario 1. Repeat at BCLK_DIV=1: frame = 64 cycles.
